// File: rtl/instruction_splitter_pkg.sv
// instruction_splitter_pkg: ISA field positions, widths, opcodes and the decoded-field record
// shared by the instruction splitter and its field decoder.
package instruction_splitter_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_W      = 5;
    localparam int IMM_W      = 17;
    localparam int TARGET_W   = 27;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RD_MSB     = 26;
    localparam int RD_LSB     = 22;
    localparam int RS_MSB     = 21;
    localparam int RS_LSB     = 17;
    localparam int RT_MSB     = 16;
    localparam int RT_LSB     = 12;
    localparam int SHAMT_MSB  = 11;
    localparam int SHAMT_LSB  = 7;
    localparam int ALUOP_MSB  = 6;
    localparam int ALUOP_LSB  = 2;
    localparam int IMM_MSB    = 16;
    localparam int TARGET_MSB = 26;

    localparam logic [REG_W-1:0] OP_RTYPE = 5'b00000;
    localparam logic [REG_W-1:0] OP_J     = 5'b00001;
    localparam logic [REG_W-1:0] OP_JAL   = 5'b00011;
    localparam logic [REG_W-1:0] OP_SETX  = 5'b10101;
    localparam logic [REG_W-1:0] OP_BEX   = 5'b10110;

    typedef struct packed {
        logic [REG_W-1:0]    opcode;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs;
        logic [REG_W-1:0]    rt;
        logic [REG_W-1:0]    shamt;
        logic [REG_W-1:0]    alu_op;
        logic [IMM_W-1:0]    immediate;
        logic [TARGET_W-1:0] target;
        logic [WORD_W-1:0]   imm_sext;
        logic                is_rtype;
        logic                is_jtype;
        logic                is_itype;
    } fields_t;

    function automatic logic is_jump_op(input logic [REG_W-1:0] op);
        return op inside {OP_J, OP_JAL, OP_SETX, OP_BEX};
    endfunction

endpackage

// File: rtl/instruction_splitter_if.sv
// instruction_splitter_if: instruction word in, registered decoded fields out.
interface instruction_splitter_if;
    logic        in_valid;
    logic [31:0] data_instruction;
    logic        out_valid;
    logic [4:0]  data_opcode;
    logic [4:0]  data_rd;
    logic [4:0]  data_rs;
    logic [4:0]  data_rt;
    logic [4:0]  data_shamt;
    logic [4:0]  data_ALUop;
    logic [16:0] data_immediate;
    logic [26:0] data_target;
    logic [31:0] data_imm_sext;
    logic        is_rtype;
    logic        is_jtype;
    logic        is_itype;

    modport master (
        output in_valid, data_instruction,
        input  out_valid, data_opcode, data_rd, data_rs, data_rt, data_shamt, data_ALUop,
               data_immediate, data_target, data_imm_sext, is_rtype, is_jtype, is_itype
    );

    modport slave (
        input  in_valid, data_instruction,
        output out_valid, data_opcode, data_rd, data_rs, data_rt, data_shamt, data_ALUop,
               data_immediate, data_target, data_imm_sext, is_rtype, is_jtype, is_itype
    );
endinterface

// File: rtl/instruction_splitter_fields.sv
// instruction_fields: combinational slicing, immediate sign extension and format class decode.
module instruction_fields
    import instruction_splitter_pkg::*;
(
    input  logic [WORD_W-1:0] i_instr,
    output fields_t           o_fields
);
    logic [REG_W-1:0] w_opcode;
    logic             w_rtype;
    logic             w_jtype;

    assign w_opcode = i_instr[OPCODE_MSB:OPCODE_LSB];
    assign w_rtype  = w_opcode == OP_RTYPE;
    assign w_jtype  = is_jump_op(w_opcode);

    always_comb begin
        o_fields           = '0;
        o_fields.opcode    = w_opcode;
        o_fields.rd        = i_instr[RD_MSB:RD_LSB];
        o_fields.rs        = i_instr[RS_MSB:RS_LSB];
        o_fields.rt        = i_instr[RT_MSB:RT_LSB];
        o_fields.shamt     = i_instr[SHAMT_MSB:SHAMT_LSB];
        o_fields.alu_op    = i_instr[ALUOP_MSB:ALUOP_LSB];
        o_fields.immediate = i_instr[IMM_MSB:0];
        o_fields.target    = i_instr[TARGET_MSB:0];
        o_fields.imm_sext  = {{(WORD_W-IMM_W){i_instr[IMM_MSB]}}, i_instr[IMM_MSB:0]};
        o_fields.is_rtype  = w_rtype;
        o_fields.is_jtype  = w_jtype;
        o_fields.is_itype  = !w_rtype && !w_jtype;
    end
endmodule

// File: rtl/instruction_splitter.sv
// instruction_splitter: captures one instruction per valid cycle and presents its decoded
// fields from registers one cycle later.
module instruction_splitter
    import instruction_splitter_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    instruction_splitter_if.slave bus
);
    fields_t w_fields;
    fields_t r_fields;
    logic    r_valid;

    instruction_fields u_fields (
        .i_instr  (bus.data_instruction),
        .o_fields (w_fields)
    );

    // Zero fields keep all class flags low until the first capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fields <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) r_fields <= w_fields;
        end
    end

    assign bus.out_valid      = r_valid;
    assign bus.data_opcode    = r_fields.opcode;
    assign bus.data_rd        = r_fields.rd;
    assign bus.data_rs        = r_fields.rs;
    assign bus.data_rt        = r_fields.rt;
    assign bus.data_shamt     = r_fields.shamt;
    assign bus.data_ALUop     = r_fields.alu_op;
    assign bus.data_immediate = r_fields.immediate;
    assign bus.data_target    = r_fields.target;
    assign bus.data_imm_sext  = r_fields.imm_sext;
    assign bus.is_rtype       = r_fields.is_rtype;
    assign bus.is_jtype       = r_fields.is_jtype;
    assign bus.is_itype       = r_fields.is_itype;
endmodule

// File: tb/tb_instruction_splitter.sv
// tb_instruction_splitter: table-driven vectors and corner sequences checked through a
// scoreboard queue of expected decoded fields.
module tb_instruction_splitter;
    import instruction_splitter_pkg::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int failures = 0;
    fields_t sb[$];

    typedef struct packed {
        logic [31:0] instr;
        fields_t     exp;
    } vec_t;

    instruction_splitter_if bus ();

    instruction_splitter u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic fields_t mk(input logic [4:0] op, rd, rs, rt, sh, alu,
                                   input logic [16:0] imm, input logic [31:0] sext,
                                   input logic [26:0] tgt, input logic r, j, i);
        fields_t f;
        f = '{op, rd, rs, rt, sh, alu, imm, tgt, sext, r, j, i};
        return f;
    endfunction

    function automatic fields_t act();
        return '{bus.data_opcode, bus.data_rd, bus.data_rs, bus.data_rt, bus.data_shamt,
                 bus.data_ALUop, bus.data_immediate, bus.data_target, bus.data_imm_sext,
                 bus.is_rtype, bus.is_jtype, bus.is_itype};
    endfunction

    task automatic chk_f(input string name, input fields_t got, input fields_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end
    endtask

    // Drive one cycle; out_valid after the next edge must equal this cycle's in_valid
    task automatic cyc(input logic v, input logic [31:0] instr, input fields_t exp);
        @(negedge clock);
        bus.in_valid = v;
        bus.data_instruction = instr;
        if (v) sb.push_back(exp);
        @(posedge clock);
        #2;
        chk_b("out_valid", bus.out_valid, v);
    endtask

    always @(posedge clock) begin
        #1;
        if (reset_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got out_valid 1 required no pending word");
            end else chk_f("fields", act(), sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[9];
        fields_t f_a, f_b, f_j, f_ones;
        f_a    = mk(13, 5, 9, 5, 5, 10, 17'h052A9, 32'h000052A9, 27'h15252A9, 0, 0, 1);
        f_b    = mk(13, 5, 9, 5, 5, 21, 17'h052D5, 32'h000052D5, 27'h15252D5, 0, 0, 1);
        f_j    = mk(1, 0, 0, 0, 0, 4, 17'h00010, 32'h00000010, 27'h0000010, 0, 1, 0);
        f_ones = mk(31, 31, 31, 31, 31, 31, 17'h1FFFF, 32'hFFFFFFFF, 27'h7FFFFFF, 0, 0, 1);
        vecs[0] = '{32'h695252A9, f_a};
        vecs[1] = '{32'h0001FFFF, mk(0, 0, 0, 31, 31, 31, 17'h1FFFF, 32'hFFFFFFFF, 27'h001FFFF, 1, 0, 0)};
        vecs[2] = '{32'h08000010, f_j};
        vecs[3] = '{32'h18000000, mk(3, 0, 0, 0, 0, 0, 17'h0, 32'h0, 27'h0, 0, 1, 0)};
        vecs[4] = '{32'hA8000000, mk(21, 0, 0, 0, 0, 0, 17'h0, 32'h0, 27'h0, 0, 1, 0)};
        vecs[5] = '{32'hB0000000, mk(22, 0, 0, 0, 0, 0, 17'h0, 32'h0, 27'h0, 0, 1, 0)};
        vecs[6] = '{32'h40018000, mk(8, 0, 0, 24, 0, 0, 17'h18000, 32'hFFFF8000, 27'h0018000, 0, 0, 1)};
        vecs[7] = '{32'hFFFFFFFF, f_ones};
        vecs[8] = '{32'h695252D5, f_b};

        bus.in_valid = 1'b0;
        bus.data_instruction = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            bus.in_valid = i[0];
            bus.data_instruction = 32'hFFFFFFFF ^ i;
            @(posedge clock);
            #2;
            chk_f("reset_fields", act(), '0);
            chk_b("reset_valid", bus.out_valid, 1'b0);
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) cyc(1'b1, vecs[i].instr, vecs[i].exp);
        cyc(1'b0, 32'h0, '0);

        cyc(1'b1, 32'h695252A9, f_a);
        cyc(1'b1, 32'h695252D5, f_b);
        cyc(1'b0, 32'h12345678, '0);

        cyc(1'b1, 32'h08000010, f_j);
        cyc(1'b0, 32'h695252A9, '0);
        chk_f("hold", act(), f_j);
        cyc(1'b0, 32'hFFFFFFFF, '0);
        chk_f("hold2", act(), f_j);

        cyc(1'b1, 32'hFFFFFFFF, f_ones);
        chk_f("pre_async", act(), f_ones);
        #1 reset_n = 1'b0;
        #1;
        chk_f("async_fields", act(), '0);
        chk_b("async_valid", bus.out_valid, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clock);
        #2;
        chk_f("reset_hold", act(), '0);
        chk_b("reset_hold_valid", bus.out_valid, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        bus.in_valid = 1'b0;
        cyc(1'b1, 32'h08000010, f_j);
        cyc(1'b0, 32'h0, '0);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_splitter.md
# instruction_splitter

Registered instruction field decoder for the 32-bit, 5-bit-opcode processor ISA. It sits between instruction fetch and register read/control. It captures one instruction word per valid cycle and presents every fixed field (opcode, rd, rs, rt, shamt, ALU op, immediate, jump target) together with a sign-extended immediate and a coarse format class, one cycle later.

## Interface
- No parameters; all widths are fixed by the ISA.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  data_instruction is valid this cycle.
- data_instruction  input  32  instruction word.
- out_valid  output  1  outputs hold a newly captured instruction.
- data_opcode  output  5  instr[31:27].
- data_rd  output  5  instr[26:22].
- data_rs  output  5  instr[21:17].
- data_rt  output  5  instr[16:12].
- data_shamt  output  5  instr[11:7].
- data_ALUop  output  5  instr[6:2].
- data_immediate  output  17  instr[16:0], raw.
- data_target  output  27  instr[26:0], raw.
- data_imm_sext  output  32  data_immediate sign-extended from bit 16.
- is_rtype  output  1  opcode == 5'b00000.
- is_jtype  output  1  opcode is one of 00001 (j), 00011 (jal), 10101 (setx), 10110 (bex).
- is_itype  output  1  neither R-type nor J-type.

## Operation
- Field extraction is a pure bit-slice. Fields overlap by design:
  - rt, shamt, ALUop and instr[1:0] all lie inside the immediate.
  - rd through instr[0] make up the target.
  - All fields are always driven, whatever the format.
- instr[1:0] is not exposed as a separate field.
- data_imm_sext = {15{instr[16]}, instr[16:0]}.
- Exactly one of is_rtype, is_itype and is_jtype is 1 whenever out_valid = 1 or a word has been captured since reset.
- After reset, before any capture, all three class flags are 0.
- The capture register is loaded only when in_valid = 1. With in_valid = 0 every field output holds its last captured value.
- Every output is a direct register output, with no combinational path from input to output.

## Timing
- Latency is 1 cycle: a word presented with in_valid = 1 at rising edge N appears on all field outputs after edge N.
- out_valid is in_valid delayed by one cycle. There is no back-pressure; a new word can be accepted every cycle.
- Back-to-back valid words each appear for exactly one cycle, in order.
- Reset (reset_n low), applied asynchronously at any time, including mid-stream:
  - all field outputs, data_imm_sext, class flags and out_valid go to 0 immediately;
  - they stay at 0 while reset_n is low.
- First capture after release: in_valid high at the first rising edge with reset_n high.

## Structure
- Shared ISA package holds:
  - field bit-position constants (OPCODE_MSB = 31, etc.);
  - field widths (5, 17, 27);
  - opcode constants OP_RTYPE, OP_J, OP_JAL, OP_SETX, OP_BEX.
- One combinational sub-module, instruction_fields, performs slicing, sign extension and class decode. The top level adds the valid pipeline and output registers.

## Test plan
- Reset: hold reset_n low, then toggle in_valid and data_instruction -> every output stays 0 and out_valid stays 0.
- Capture 0x695252A9 with in_valid = 1 -> one cycle later:
  - opcode 13, rd 5, rs 9, rt 5, shamt 5, ALUop 10;
  - immediate 0x052A9, imm_sext 0x000052A9, target 0x15252A9;
  - is_itype = 1, out_valid = 1.
- Capture 0x695252A9, then 0x695252D5 on consecutive cycles:
  - second result has ALUop 21 and immediate 0x052D5;
  - out_valid is 1 for both cycles, then 0.
- Capture 0x0001FFFF -> opcode 0, is_rtype = 1, immediate 0x1FFFF, imm_sext 0xFFFFFFFF.
- Capture 0x08000010 (j) -> is_jtype = 1, target 0x0000010. Then drop in_valid with a new data_instruction -> fields unchanged, out_valid = 0.
- Assert reset_n low mid-stream, between clock edges -> outputs 0 without waiting for a clock edge.
